// File: rtl/systemne_nios2_qsys_0_oci_dct_packer_if.sv
// Handshake bundle between the OCI trace source, the DCT packer and the
// DCT consumer. The packer connects through the master modport; the
// environment (trace source + trace sink) uses the slave modport.
interface systemne_nios2_qsys_0_oci_dct_packer_if #(
   parameter int SYM_W = 2,
   parameter int SLOTS = 15
);
   // trace symbol side
   logic                     sym_valid;
   logic [SYM_W-1:0]         sym_data;
   logic                     sym_ready;
   logic                     flush;
   logic                     end_req;
   // capture word side
   logic [SYM_W*SLOTS-1:0]   dct_buffer;
   logic [3:0]               dct_count;
   logic                     dct_valid;
   logic                     dct_ready;
   // end-of-test status
   logic                     test_ending;
   logic                     test_has_ended;

   modport master (
      input  sym_valid, sym_data, flush, end_req, dct_ready,
      output sym_ready, dct_buffer, dct_count, dct_valid,
             test_ending, test_has_ended
   );

   modport slave (
      output sym_valid, sym_data, flush, end_req, dct_ready,
      input  sym_ready, dct_buffer, dct_count, dct_valid,
             test_ending, test_has_ended
   );
endinterface

// File: rtl/systemne_nios2_qsys_0_oci_dct_packer.sv
// OCI DCT producer: packs 2-bit trace symbols into a 15-slot capture word,
// hands the word to the consumer under valid/ready, and sequences the
// end-of-test indication (test_ending, then sticky test_has_ended).
module systemne_nios2_qsys_0_oci_dct_packer #(
   parameter int SYM_W            = 2,
   parameter int SLOTS            = 15,
   parameter int END_DRAIN_CYCLES = 4
) (
   input logic clk,
   input logic reset,
   systemne_nios2_qsys_0_oci_dct_packer_if.master bus
);
   localparam int         BUF_W = SYM_W * SLOTS;
   localparam logic [3:0] FULL  = 4'(SLOTS);
   localparam logic [7:0] DRAIN = 8'(END_DRAIN_CYCLES - 1);

   typedef enum logic [1:0] {FILL, HOLD, ENDING, ENDED} state_t;

   state_t           state;
   logic [BUF_W-1:0] buf_q;
   logic [3:0]       cnt_q;
   logic             dct_valid_q;
   logic             sym_ready_q;
   logic             test_ending_q;
   logic             test_has_ended_q;
   logic             end_pending;
   logic [7:0]       drain;

   logic             accept;
   logic [3:0]       cnt_after;
   logic [BUF_W-1:0] buf_next;

   // Word contents as they will be after this cycle's symbol (if any) lands;
   // the FILL decisions look at this so a same-cycle symbol is never lost.
   always_comb begin
      accept    = (state == FILL) && bus.sym_valid && sym_ready_q;
      cnt_after = cnt_q + {3'd0, accept};
      buf_next  = buf_q;
      if (accept)
         buf_next[int'(cnt_q)*SYM_W +: SYM_W] = bus.sym_data;
   end

   // Packer state machine; every output is a register updated here.
   always_ff @(posedge clk) begin
      if (reset) begin
         state            <= FILL;
         buf_q            <= '0;
         cnt_q            <= '0;
         dct_valid_q      <= 1'b0;
         sym_ready_q      <= 1'b0;
         test_ending_q    <= 1'b0;
         test_has_ended_q <= 1'b0;
         end_pending      <= 1'b0;
         drain            <= '0;
      end else begin
         case (state)
            FILL: begin
               buf_q <= buf_next;
               cnt_q <= cnt_after;
               if (bus.end_req) begin
                  // end_req wins over flush; either way the partial word goes out
                  end_pending <= 1'b1;
                  sym_ready_q <= 1'b0;
                  if (cnt_after != 4'd0) begin
                     state       <= HOLD;
                     dct_valid_q <= 1'b1;
                  end else begin
                     state         <= ENDING;
                     test_ending_q <= 1'b1;
                     drain         <= DRAIN;
                  end
               end else if (cnt_after == FULL ||
                            (bus.flush && cnt_after != 4'd0)) begin
                  state       <= HOLD;
                  dct_valid_q <= 1'b1;
                  sym_ready_q <= 1'b0;
               end else begin
                  sym_ready_q <= 1'b1;
               end
            end
            HOLD: begin
               if (bus.dct_ready) begin
                  buf_q       <= '0;
                  cnt_q       <= '0;
                  dct_valid_q <= 1'b0;
                  if (end_pending || bus.end_req) begin
                     end_pending   <= 1'b1;
                     state         <= ENDING;
                     test_ending_q <= 1'b1;
                     drain         <= DRAIN;
                  end else begin
                     // zero-bubble return: source may push again next cycle
                     state       <= FILL;
                     sym_ready_q <= 1'b1;
                  end
               end else if (bus.end_req) begin
                  end_pending <= 1'b1;
               end
            end
            ENDING: begin
               if (drain == 8'd0) begin
                  state            <= ENDED;
                  test_has_ended_q <= 1'b1;
               end else begin
                  drain <= drain - 8'd1;
               end
            end
            default: begin
               // ENDED is terminal until reset
               state <= ENDED;
            end
         endcase
      end
   end

   assign bus.dct_buffer     = buf_q;
   assign bus.dct_count      = cnt_q;
   assign bus.dct_valid      = dct_valid_q;
   assign bus.sym_ready      = sym_ready_q;
   assign bus.test_ending    = test_ending_q;
   assign bus.test_has_ended = test_has_ended_q;
endmodule

// File: tb/tb_systemne_nios2_qsys_0_oci_dct_packer.sv
// Directed bench for the DCT packer. Stimulus pushes the expected
// {count, buffer} of every beat into a queue; a negedge monitor pops and
// compares whenever a beat handshakes.
module tb_systemne_nios2_qsys_0_oci_dct_packer;
   logic clk;
   logic reset;

   systemne_nios2_qsys_0_oci_dct_packer_if #(.SYM_W(2), .SLOTS(15)) bus ();

   systemne_nios2_qsys_0_oci_dct_packer #(
      .SYM_W(2), .SLOTS(15), .END_DRAIN_CYCLES(4)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int pass_cnt = 0;
   int total    = 0;
   logic [33:0] exp_q[$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [33:0] act, input logic [33:0] exp);
      total++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offer one symbol and hold it until accepted; leaves sym_valid high so
   // the caller can chain symbols back-to-back.
   task automatic send(input logic [1:0] d, inout int stalls);
      int guard;
      guard = 0;
      bus.sym_valid = 1'b1;
      bus.sym_data  = d;
      while (!bus.sym_ready && guard < 50) begin
         tick();
         stalls++;
         guard++;
      end
      if (guard >= 50) chk("send_timeout", 34'd1, 34'd0);
      tick();
   endtask

   task automatic pulse_flush();
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
   endtask

   // Beat monitor: compare every handshaken word against the queue head.
   always @(negedge clk) begin
      if (!reset && bus.dct_valid && bus.dct_ready) begin
         if (exp_q.size() == 0) chk("unexpected_beat", {bus.dct_count, bus.dct_buffer}, 34'h0);
         else chk("beat", {bus.dct_count, bus.dct_buffer}, exp_q.pop_front());
      end
   end

   initial begin
      int stalls;
      bus.sym_valid = 1'b0;
      bus.sym_data  = 2'd0;
      bus.flush     = 1'b0;
      bus.end_req   = 1'b0;
      bus.dct_ready = 1'b1;
      reset = 1'b1;
      tick(); tick();

      // reset state
      chk("reset_outputs", {bus.dct_valid, bus.sym_ready, bus.test_ending,
          bus.test_has_ended, bus.dct_count, bus.dct_buffer}, 34'h0);
      reset = 1'b0;
      tick();
      chk("sym_ready_after_reset", {33'd0, bus.sym_ready}, 34'd1);

      // full word, slot i = i mod 4, back-to-back
      exp_q.push_back({4'd15, 30'h24E4E4E4});
      stalls = 0;
      for (int i = 0; i < 15; i++) send(2'(i % 4), stalls);
      bus.sym_valid = 1'b0;
      chk("full_no_stall", 34'(stalls), 34'd0);
      chk("hold_sym_ready_low", {33'd0, bus.sym_ready}, 34'd0);
      tick();
      chk("sym_ready_back", {33'd0, bus.sym_ready}, 34'd1);

      // flush on an empty word produces nothing
      pulse_flush();
      tick();
      chk("empty_flush_no_valid", {33'd0, bus.dct_valid}, 34'd0);

      // 3,2,1 then flush
      exp_q.push_back({4'd3, 30'h0000001B});
      for (int i = 0; i < 3; i++) send(2'(3 - i), stalls);
      bus.sym_valid = 1'b0;
      pulse_flush();
      tick();

      // back-pressure for 10 cycles on a full word of 3s
      bus.dct_ready = 1'b0;
      exp_q.push_back({4'd15, 30'h3FFFFFFF});
      for (int i = 0; i < 15; i++) send(2'd3, stalls);
      bus.sym_valid = 1'b0;
      for (int i = 0; i < 10; i++) begin
         chk("hold_stable", {bus.dct_valid, bus.sym_ready, bus.dct_count, bus.dct_buffer[27:0]},
             {1'b1, 1'b0, 4'd15, 28'hFFFFFFF});
         tick();
      end
      bus.dct_ready = 1'b1;
      tick();
      chk("hold_released", {33'd0, bus.dct_valid}, 34'd0);

      // symbol accepted together with flush at count 4
      exp_q.push_back({4'd5, 30'h00000339});
      for (int i = 0; i < 4; i++) send(2'((i + 1) % 4), stalls);
      bus.sym_valid = 1'b0;
      chk("ready_before_flush_sym", {33'd0, bus.sym_ready}, 34'd1);
      bus.sym_valid = 1'b1;
      bus.sym_data  = 2'd3;
      bus.flush     = 1'b1;
      tick();
      bus.sym_valid = 1'b0;
      bus.flush     = 1'b0;
      tick();

      // end_req at count 2 (flush in same cycle is overridden)
      exp_q.push_back({4'd2, 30'h00000006});
      send(2'd2, stalls);
      send(2'd1, stalls);
      bus.sym_valid = 1'b0;
      bus.end_req   = 1'b1;
      bus.flush     = 1'b1;
      tick();
      bus.end_req = 1'b0;
      bus.flush   = 1'b0;
      chk("end_beat_presented", {32'd0, bus.dct_valid, bus.test_ending}, 34'b10);
      tick();
      for (int i = 0; i < 4; i++) begin
         chk("ending_window", {32'd0, bus.test_ending, bus.test_has_ended}, 34'b10);
         tick();
      end
      chk("has_ended", {32'd0, bus.test_ending, bus.test_has_ended}, 34'b11);
      bus.sym_valid = 1'b1;
      bus.sym_data  = 2'd1;
      pulse_flush();
      tick(); tick();
      bus.sym_valid = 1'b0;
      chk("ended_sticky", {31'd0, bus.test_has_ended, bus.sym_ready, bus.dct_valid}, 34'b100);

      // reset while holding a 7-symbol word
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tick();
      bus.dct_ready = 1'b0;
      for (int i = 0; i < 7; i++) send(2'd1, stalls);
      bus.sym_valid = 1'b0;
      pulse_flush();
      chk("partial_hold", {29'd0, bus.dct_valid, bus.dct_count}, {29'd0, 1'b1, 4'd7});
      reset = 1'b1;
      tick();
      chk("reset_midhold", {bus.dct_valid, bus.sym_ready, bus.test_ending,
          bus.test_has_ended, bus.dct_count, bus.dct_buffer}, 34'h0);
      reset = 1'b0;
      bus.dct_ready = 1'b1;
      tick();
      chk("resume_ready", {33'd0, bus.sym_ready}, 34'd1);
      exp_q.push_back({4'd1, 30'h00000002});
      send(2'd2, stalls);
      bus.sym_valid = 1'b0;
      pulse_flush();
      tick(); tick();

      chk("queue_drained", 34'(exp_q.size()), 34'd0);
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end
endmodule
